// File: rtl/bootloader_arbiter.sv
// Arbitrates ownership of the spi_bootloader byte streams between UART0, UART1 and the I2C FSM.
// Latency: claim -> owner/bl_reset next cycle, forwarding two cycles after the claim; data path is zero-latency.
// Backpressure: owner streams pass ready/valid straight through; non-owners are always ready (bytes dropped).
//
// Ports:
//   clk, resetn                         clock, async active-low reset
//   hN_in_valid/_data/_ready  (N=0..2)  host N -> bootloader byte stream
//   hN_out_valid/_data/_ready (N=0..2)  bootloader -> host N byte stream
//   h0_break, h1_break, h2_reset        per-host release strobes (honoured only from the owner)
//   bl_in_*, bl_out_*, bl_busy          bootloader-side streams and busy flag
//   bl_reset                            one-cycle bootloader reset on every ownership change
//   owner                               0/1/2 = granted host, 3 = none
//   h0_tx_oe, h1_tx_oe                  UART TX pin enables while that UART holds ownership
module bootloader_arbiter #(
    parameter logic [7:0]  MAGIC_BYTE     = 8'hbc,
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       h0_in_valid,
    input  logic [7:0] h0_in_data,
    output logic       h0_in_ready,
    input  logic       h1_in_valid,
    input  logic [7:0] h1_in_data,
    output logic       h1_in_ready,
    input  logic       h2_in_valid,
    input  logic [7:0] h2_in_data,
    output logic       h2_in_ready,
    output logic       h0_out_valid,
    output logic [7:0] h0_out_data,
    input  logic       h0_out_ready,
    output logic       h1_out_valid,
    output logic [7:0] h1_out_data,
    input  logic       h1_out_ready,
    output logic       h2_out_valid,
    output logic [7:0] h2_out_data,
    input  logic       h2_out_ready,
    input  logic       h0_break,
    input  logic       h1_break,
    input  logic       h2_reset,
    output logic       bl_in_valid,
    output logic [7:0] bl_in_data,
    input  logic       bl_in_ready,
    input  logic       bl_out_valid,
    input  logic [7:0] bl_out_data,
    output logic       bl_out_ready,
    input  logic       bl_busy,
    output logic       bl_reset,
    output logic [1:0] owner,
    output logic       h0_tx_oe,
    output logic       h1_tx_oe
);

    localparam int unsigned       CNT_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]        OWNER_NONE = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_CLAIM, ST_OWNED} state_e;

    state_e           state_q;
    logic [1:0]       owner_q;
    logic             bl_reset_q;
    logic [CNT_W-1:0] cnt_q;

    logic       owned;
    logic       own_break;
    logic       timeout;
    logic       release_evt;
    logic       sel_in_valid;
    logic [7:0] sel_in_data;
    logic       sel_out_ready;
    logic       claim0, claim1, claim2;

    assign owned = (state_q == ST_OWNED);

    // Owner-side signal selection; only meaningful while owned.
    always_comb begin
        own_break     = 1'b0;
        sel_in_valid  = 1'b0;
        sel_in_data   = 8'h00;
        sel_out_ready = 1'b0;
        case (owner_q)
            2'd0: begin own_break = h0_break; sel_in_valid = h0_in_valid; sel_in_data = h0_in_data; sel_out_ready = h0_out_ready; end
            2'd1: begin own_break = h1_break; sel_in_valid = h1_in_valid; sel_in_data = h1_in_data; sel_out_ready = h1_out_ready; end
            2'd2: begin own_break = h2_reset; sel_in_valid = h2_in_valid; sel_in_data = h2_in_data; sel_out_ready = h2_out_ready; end
            default: ;
        endcase
    end

    assign timeout     = (cnt_q == CNT_LAST);
    assign release_evt = owned && (own_break || timeout);

    // UART ready is 1 in IDLE, so a valid magic byte is also a completed handshake.
    assign claim0 = h0_in_valid && (h0_in_data == MAGIC_BYTE);
    assign claim1 = h1_in_valid && (h1_in_data == MAGIC_BYTE);
    assign claim2 = h2_in_valid;

    // Stream routing. A release in the same cycle suppresses both halves of any
    // owner handshake so no byte is half-transferred across the reset.
    always_comb begin
        h0_in_ready  = 1'b0;
        h1_in_ready  = 1'b0;
        h2_in_ready  = 1'b0;
        h0_out_valid = 1'b0;
        h1_out_valid = 1'b0;
        h2_out_valid = 1'b0;
        bl_in_valid  = 1'b0;
        bl_in_data   = 8'h00;
        bl_out_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                h0_in_ready = 1'b1;
                h1_in_ready = 1'b1;
            end
            ST_OWNED: begin
                h0_in_ready  = 1'b1;
                h1_in_ready  = 1'b1;
                h2_in_ready  = 1'b1;
                bl_in_valid  = sel_in_valid && !release_evt;
                bl_in_data   = sel_in_data;
                bl_out_ready = sel_out_ready && !release_evt;
                case (owner_q)
                    2'd0: begin h0_in_ready = bl_in_ready && !release_evt; h0_out_valid = bl_out_valid && !release_evt; end
                    2'd1: begin h1_in_ready = bl_in_ready && !release_evt; h1_out_valid = bl_out_valid && !release_evt; end
                    2'd2: begin h2_in_ready = bl_in_ready && !release_evt; h2_out_valid = bl_out_valid && !release_evt; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign h0_out_data = bl_out_data;
    assign h1_out_data = bl_out_data;
    assign h2_out_data = bl_out_data;

    assign bl_reset = bl_reset_q;
    assign owner    = owner_q;
    assign h0_tx_oe = (owner_q == 2'd0) && (state_q != ST_IDLE);
    assign h1_tx_oe = (owner_q == 2'd1) && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_NONE;
            bl_reset_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            bl_reset_q <= 1'b0;
            cnt_q      <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (claim0 || claim1 || claim2) begin
                        state_q    <= ST_CLAIM;
                        owner_q    <= claim0 ? 2'd0 : (claim1 ? 2'd1 : 2'd2);
                        bl_reset_q <= 1'b1;
                    end
                end
                ST_CLAIM: state_q <= ST_OWNED;
                ST_OWNED: begin
                    if (release_evt) begin
                        state_q    <= ST_IDLE;
                        owner_q    <= OWNER_NONE;
                        bl_reset_q <= 1'b1;
                    end else if (!((bl_in_valid && bl_in_ready) || (bl_out_valid && bl_out_ready) || bl_busy)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWNER_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bootloader_arbiter.sv
module tb_bootloader_arbiter;
    localparam int         TO    = 16;
    localparam logic [7:0] MAGIC = 8'hbc;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] hin_vld;
    logic [7:0] hin_dat [3];
    logic [2:0] hout_rdy;
    logic       h0_break, h1_break, h2_reset;
    logic       bl_in_ready, bl_out_valid, bl_busy;
    logic [7:0] bl_out_data;
    wire  [2:0] hin_rdy, hout_vld;
    wire  [7:0] hout_dat0, hout_dat1, hout_dat2, bl_in_data;
    wire        bl_in_valid, bl_out_ready, bl_reset, h0_tx_oe, h1_tx_oe;
    wire  [1:0] owner;

    int total = 0;
    int bad = 0;

    bootloader_arbiter #(.MAGIC_BYTE(MAGIC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .h0_in_valid(hin_vld[0]), .h0_in_data(hin_dat[0]), .h0_in_ready(hin_rdy[0]),
        .h1_in_valid(hin_vld[1]), .h1_in_data(hin_dat[1]), .h1_in_ready(hin_rdy[1]),
        .h2_in_valid(hin_vld[2]), .h2_in_data(hin_dat[2]), .h2_in_ready(hin_rdy[2]),
        .h0_out_valid(hout_vld[0]), .h0_out_data(hout_dat0), .h0_out_ready(hout_rdy[0]),
        .h1_out_valid(hout_vld[1]), .h1_out_data(hout_dat1), .h1_out_ready(hout_rdy[1]),
        .h2_out_valid(hout_vld[2]), .h2_out_data(hout_dat2), .h2_out_ready(hout_rdy[2]),
        .h0_break(h0_break), .h1_break(h1_break), .h2_reset(h2_reset),
        .bl_in_valid(bl_in_valid), .bl_in_data(bl_in_data), .bl_in_ready(bl_in_ready),
        .bl_out_valid(bl_out_valid), .bl_out_data(bl_out_data), .bl_out_ready(bl_out_ready),
        .bl_busy(bl_busy), .bl_reset(bl_reset), .owner(owner),
        .h0_tx_oe(h0_tx_oe), .h1_tx_oe(h1_tx_oe)
    );

    // Reference model: who owns, whether we are in the one-cycle claim gap,
    // whether a reset pulse is due, and how long the owner has been quiet.
    typedef struct packed {
        logic [2:0] in_rdy;
        logic [2:0] out_vld;
        logic       bl_in_vld;
        logic [7:0] bl_in_dat;
        logic       bl_out_rdy;
        logic [1:0] own;
        logic       blr;
        logic [1:0] oe;
        logic       rel;
    } exp_t;

    logic [1:0] m_own;
    logic       m_claiming, m_pulse;
    int         m_quiet;
    exp_t       m_exp;

    always_comb begin
        m_exp = '0;
        m_exp.own = m_own;
        m_exp.blr = m_pulse;
        m_exp.oe  = {m_own == 2'd1, m_own == 2'd0};
        if (m_own == 2'd3) begin
            m_exp.in_rdy = 3'b011;
        end else if (!m_claiming) begin
            m_exp.rel = (m_own == 2'd0 && h0_break) || (m_own == 2'd1 && h1_break) ||
                        (m_own == 2'd2 && h2_reset) || (m_quiet == TO - 1);
            m_exp.in_rdy = 3'b111;
            m_exp.in_rdy[m_own]  = bl_in_ready && !m_exp.rel;
            m_exp.bl_in_vld      = hin_vld[m_own] && !m_exp.rel;
            m_exp.bl_in_dat      = hin_dat[m_own];
            m_exp.bl_out_rdy     = hout_rdy[m_own] && !m_exp.rel;
            m_exp.out_vld[m_own] = bl_out_valid && !m_exp.rel;
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_own <= 2'd3; m_claiming <= 1'b0; m_pulse <= 1'b0; m_quiet <= 0;
        end else if (m_claiming) begin
            m_claiming <= 1'b0; m_pulse <= 1'b0; m_quiet <= 0;
        end else if (m_own != 2'd3) begin
            if (m_exp.rel) begin
                m_own <= 2'd3; m_pulse <= 1'b1; m_quiet <= 0;
            end else begin
                m_pulse <= 1'b0;
                if ((m_exp.bl_in_vld && bl_in_ready) || (bl_out_valid && m_exp.bl_out_rdy) || bl_busy) m_quiet <= 0;
                else m_quiet <= m_quiet + 1;
            end
        end else begin
            m_pulse <= 1'b0; m_quiet <= 0;
            if (hin_vld[0] && hin_dat[0] == MAGIC) begin m_own <= 2'd0; m_claiming <= 1'b1; m_pulse <= 1'b1; end
            else if (hin_vld[1] && hin_dat[1] == MAGIC) begin m_own <= 2'd1; m_claiming <= 1'b1; m_pulse <= 1'b1; end
            else if (hin_vld[2]) begin m_own <= 2'd2; m_claiming <= 1'b1; m_pulse <= 1'b1; end
        end
    end

    task automatic quiet_inputs();
        hin_vld = 3'b000; hin_dat[0] = 8'h00; hin_dat[1] = 8'h00; hin_dat[2] = 8'h00;
        hout_rdy = 3'b111; h0_break = 1'b0; h1_break = 1'b0; h2_reset = 1'b0;
        bl_in_ready = 1'b1; bl_out_valid = 1'b0; bl_out_data = 8'h00; bl_busy = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs(); hin_vld[2] = 1'b1; hin_dat[2] = 8'h33; resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (owner !== 2'd3) begin bad++; $display("FAIL rst_owner got=%0d exp=3", owner); end
        total++; if (bl_reset !== 1'b0) begin bad++; $display("FAIL rst_bl_reset got=%b exp=0", bl_reset); end
        total++; if (hin_rdy !== 3'b011) begin bad++; $display("FAIL rst_in_ready got=%b exp=011", hin_rdy); end
        total++; if ({bl_in_valid, hout_vld, h1_tx_oe, h0_tx_oe} !== 6'b0) begin bad++; $display("FAIL rst_valids got=%b exp=000000", {bl_in_valid, hout_vld, h1_tx_oe, h0_tx_oe}); end
        @(negedge clk); hin_vld = 3'b000; resetn = 1'b1; #1;
        total++; if (owner !== 2'd3) begin bad++; $display("FAIL rst_release_owner got=%0d exp=3", owner); end
    endtask

    task automatic test_uart_claim();
        @(negedge clk); hin_vld[1] = 1'b1; hin_dat[1] = 8'h12; #1;
        total++; if (hin_rdy[1] !== 1'b1 || bl_in_valid !== 1'b0) begin bad++; $display("FAIL uc_drop got=%b%b exp=10", hin_rdy[1], bl_in_valid); end
        @(negedge clk); hin_dat[1] = MAGIC; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b0) begin bad++; $display("FAIL uc_no_claim got=%0d/%b exp=3/0", owner, bl_reset); end
        @(negedge clk); hin_dat[1] = 8'h05; #1;
        total++; if (owner !== 2'd1 || bl_reset !== 1'b1) begin bad++; $display("FAIL uc_claim got=%0d/%b exp=1/1", owner, bl_reset); end
        total++; if (hin_rdy !== 3'b000 || h1_tx_oe !== 1'b1 || bl_in_valid !== 1'b0) begin bad++; $display("FAIL uc_claim_gap got=%b/%b/%b exp=000/1/0", hin_rdy, h1_tx_oe, bl_in_valid); end
        @(negedge clk); #1;
        total++; if (bl_in_valid !== 1'b1 || bl_in_data !== 8'h05) begin bad++; $display("FAIL uc_fwd got=%b/%h exp=1/05", bl_in_valid, bl_in_data); end
        total++; if (hin_rdy[1] !== 1'b1 || bl_reset !== 1'b0) begin bad++; $display("FAIL uc_fwd_rdy got=%b/%b exp=1/0", hin_rdy[1], bl_reset); end
        @(negedge clk); hin_dat[1] = 8'h06; h1_break = 1'b1; #1;
        total++; if (hin_rdy[1] !== 1'b0 || bl_in_valid !== 1'b0) begin bad++; $display("FAIL uc_rel_wins got=%b/%b exp=0/0", hin_rdy[1], bl_in_valid); end
        @(negedge clk); hin_vld = 3'b000; h1_break = 1'b0; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b1 || h1_tx_oe !== 1'b0) begin bad++; $display("FAIL uc_release got=%0d/%b/%b exp=3/1/0", owner, bl_reset, h1_tx_oe); end
        @(negedge clk); #1;
        total++; if (bl_reset !== 1'b0) begin bad++; $display("FAIL uc_pulse_width got=%b exp=0", bl_reset); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk); hin_vld = 3'b011; hin_dat[0] = MAGIC; hin_dat[1] = MAGIC; #1;
        total++; if (hin_rdy[1:0] !== 2'b11) begin bad++; $display("FAIL sc_rdy got=%b exp=11", hin_rdy[1:0]); end
        @(negedge clk); hin_vld = 3'b000; #1;
        total++; if (owner !== 2'd0 || bl_reset !== 1'b1) begin bad++; $display("FAIL sc_prio got=%0d/%b exp=0/1", owner, bl_reset); end
        @(negedge clk); hin_vld[1] = 1'b1; hin_dat[1] = MAGIC; #1;
        total++; if (hin_rdy[1] !== 1'b1 || bl_in_valid !== 1'b0) begin bad++; $display("FAIL sc_nonowner_drop got=%b/%b exp=1/0", hin_rdy[1], bl_in_valid); end
        @(negedge clk); hin_vld = 3'b000; #1;
        total++; if (owner !== 2'd0 || bl_reset !== 1'b0) begin bad++; $display("FAIL sc_no_steal got=%0d/%b exp=0/0", owner, bl_reset); end
        @(negedge clk); h0_break = 1'b1; #1;
        @(negedge clk); h0_break = 1'b0; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b1) begin bad++; $display("FAIL sc_release got=%0d/%b exp=3/1", owner, bl_reset); end
    endtask

    task automatic test_i2c_claim();
        @(negedge clk); hin_vld[2] = 1'b1; hin_dat[2] = 8'h0a; #1;
        total++; if (hin_rdy[2] !== 1'b0) begin bad++; $display("FAIL i2c_hold got=%b exp=0", hin_rdy[2]); end
        @(negedge clk); #1;
        total++; if (owner !== 2'd2 || bl_reset !== 1'b1 || hin_rdy[2] !== 1'b0) begin bad++; $display("FAIL i2c_claim got=%0d/%b/%b exp=2/1/0", owner, bl_reset, hin_rdy[2]); end
        @(negedge clk); #1;
        total++; if (bl_in_valid !== 1'b1 || bl_in_data !== 8'h0a || hin_rdy[2] !== 1'b1) begin bad++; $display("FAIL i2c_fwd got=%b/%h/%b exp=1/0a/1", bl_in_valid, bl_in_data, hin_rdy[2]); end
        @(negedge clk); hin_vld = 3'b000; h0_break = 1'b1; h1_break = 1'b1; #1;
        @(negedge clk); h0_break = 1'b0; h1_break = 1'b0; #1;
        total++; if (owner !== 2'd2 || bl_reset !== 1'b0) begin bad++; $display("FAIL i2c_foreign_break got=%0d/%b exp=2/0", owner, bl_reset); end
        @(negedge clk); h2_reset = 1'b1; #1;
        @(negedge clk); h2_reset = 1'b0; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b1) begin bad++; $display("FAIL i2c_release got=%0d/%b exp=3/1", owner, bl_reset); end
    endtask

    task automatic test_outbound_break();
        @(negedge clk); hin_vld[0] = 1'b1; hin_dat[0] = MAGIC; #1;
        @(negedge clk); hin_vld = 3'b000; #1;
        total++; if (h0_tx_oe !== 1'b1) begin bad++; $display("FAIL ob_tx_oe got=%b exp=1", h0_tx_oe); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); bl_out_valid = 1'b1; bl_out_data = (k == 0) ? 8'h55 : 8'haa; #1;
            total++; if (hout_vld !== 3'b001 || hout_dat0 !== bl_out_data || bl_out_ready !== 1'b1) begin bad++; $display("FAIL ob_byte%0d got=%b/%h/%b exp=001/%h/1", k, hout_vld, hout_dat0, bl_out_ready, bl_out_data); end
        end
        @(negedge clk); h0_break = 1'b1; #1;
        total++; if (hout_vld !== 3'b000 || bl_out_ready !== 1'b0) begin bad++; $display("FAIL ob_rel_wins got=%b/%b exp=000/0", hout_vld, bl_out_ready); end
        @(negedge clk); h0_break = 1'b0; bl_out_valid = 1'b0; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b1 || h0_tx_oe !== 1'b0) begin bad++; $display("FAIL ob_release got=%0d/%b/%b exp=3/1/0", owner, bl_reset, h0_tx_oe); end
    endtask

    task automatic test_timeout(input int busy_cycles);
        @(negedge clk); hin_vld[1] = 1'b1; hin_dat[1] = MAGIC; #1;
        @(negedge clk); hin_vld = 3'b000; #1;
        for (int k = 0; k < busy_cycles + TO; k++) begin
            @(negedge clk); bl_busy = (k < busy_cycles); #1;
            total++; if (owner !== 2'd1) begin bad++; $display("FAIL to_early busy=%0d k=%0d got=%0d exp=1", busy_cycles, k, owner); end
        end
        @(negedge clk); bl_busy = 1'b0; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b1) begin bad++; $display("FAIL to_release busy=%0d got=%0d/%b exp=3/1", busy_cycles, owner, bl_reset); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); hin_vld[1] = 1'b1; hin_dat[1] = MAGIC; #1;
        @(negedge clk); hin_vld = 3'b000; #1;
        @(negedge clk); h1_break = 1'b1; #1;
        @(negedge clk); h1_break = 1'b0; hin_vld[0] = 1'b1; hin_dat[0] = MAGIC; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b1 || hin_rdy[0] !== 1'b1) begin bad++; $display("FAIL b2b_release got=%0d/%b/%b exp=3/1/1", owner, bl_reset, hin_rdy[0]); end
        @(negedge clk); hin_vld = 3'b000; #1;
        total++; if (owner !== 2'd0 || bl_reset !== 1'b1) begin bad++; $display("FAIL b2b_reclaim got=%0d/%b exp=0/1", owner, bl_reset); end
        @(negedge clk); h0_break = 1'b1; #1;
        @(negedge clk); h0_break = 1'b0; #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); hin_vld[2] = 1'b1; hin_dat[2] = 8'h40; #1;
        @(negedge clk); #1;
        @(negedge clk); bl_out_valid = 1'b1; bl_out_data = 8'h77; #1;
        total++; if (hout_vld !== 3'b100 || bl_in_valid !== 1'b1) begin bad++; $display("FAIL rm_owned got=%b/%b exp=100/1", hout_vld, bl_in_valid); end
        #2; resetn = 1'b0; #1;
        total++; if (owner !== 2'd3 || bl_reset !== 1'b0 || hin_rdy !== 3'b011) begin bad++; $display("FAIL rm_async got=%0d/%b/%b exp=3/0/011", owner, bl_reset, hin_rdy); end
        total++; if ({bl_in_valid, hout_vld, h1_tx_oe, h0_tx_oe} !== 6'b0) begin bad++; $display("FAIL rm_async_vld got=%b exp=000000", {bl_in_valid, hout_vld, h1_tx_oe, h0_tx_oe}); end
        @(negedge clk); #1;
        total++; if (bl_reset !== 1'b0) begin bad++; $display("FAIL rm_no_pulse got=%b exp=0", bl_reset); end
        @(negedge clk); quiet_inputs(); resetn = 1'b1; hin_vld[0] = 1'b1; hin_dat[0] = MAGIC; #1;
        @(negedge clk); hin_vld = 3'b000; #1;
        total++; if (owner !== 2'd0 || bl_reset !== 1'b1) begin bad++; $display("FAIL rm_fresh_claim got=%0d/%b exp=0/1", owner, bl_reset); end
        @(negedge clk); #1;
        @(negedge clk); h0_break = 1'b1; #1;
        @(negedge clk); h0_break = 1'b0; #1;
    endtask

    task automatic test_random();
        logic busy_st;
        busy_st = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            for (int h = 0; h < 3; h++) begin
                hin_dat[h] = ($urandom_range(0, 3) == 0) ? MAGIC : 8'($urandom);
                hout_rdy[h] = 1'($urandom);
            end
            hin_vld[0] = 1'($urandom); hin_vld[1] = 1'($urandom);
            hin_vld[2] = ($urandom_range(0, 7) == 0);
            h0_break = ($urandom_range(0, 24) == 0); h1_break = ($urandom_range(0, 24) == 0);
            h2_reset = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) busy_st = ~busy_st;
            bl_busy = busy_st;
            bl_in_ready = ($urandom_range(0, 3) != 0);
            bl_out_valid = ($urandom_range(0, 2) == 0);
            bl_out_data = 8'($urandom);
            #1;
            total++; if (hin_rdy !== m_exp.in_rdy) begin bad++; $display("FAIL rnd_in_ready i=%0d got=%b exp=%b", i, hin_rdy, m_exp.in_rdy); end
            total++; if (hout_vld !== m_exp.out_vld) begin bad++; $display("FAIL rnd_out_valid i=%0d got=%b exp=%b", i, hout_vld, m_exp.out_vld); end
            total++; if (bl_in_valid !== m_exp.bl_in_vld || bl_out_ready !== m_exp.bl_out_rdy) begin bad++; $display("FAIL rnd_bl_hs i=%0d got=%b%b exp=%b%b", i, bl_in_valid, bl_out_ready, m_exp.bl_in_vld, m_exp.bl_out_rdy); end
            if (m_exp.bl_in_vld) begin
                total++; if (bl_in_data !== m_exp.bl_in_dat) begin bad++; $display("FAIL rnd_bl_in_data i=%0d got=%h exp=%h", i, bl_in_data, m_exp.bl_in_dat); end
            end
            if (m_exp.out_vld != 3'b000) begin
                total++; if ({hout_dat2, hout_dat1, hout_dat0} !== {3{bl_out_data}}) begin bad++; $display("FAIL rnd_out_data i=%0d got=%h/%h/%h exp=%h", i, hout_dat0, hout_dat1, hout_dat2, bl_out_data); end
            end
            total++; if (owner !== m_exp.own || bl_reset !== m_exp.blr) begin bad++; $display("FAIL rnd_owner i=%0d got=%0d/%b exp=%0d/%b", i, owner, bl_reset, m_exp.own, m_exp.blr); end
            total++; if ({h1_tx_oe, h0_tx_oe} !== m_exp.oe) begin bad++; $display("FAIL rnd_tx_oe i=%0d got=%b exp=%b", i, {h1_tx_oe, h0_tx_oe}, m_exp.oe); end
        end
        @(negedge clk); quiet_inputs();
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_uart_claim();
        test_same_cycle();
        test_i2c_claim();
        test_outbound_break();
        test_timeout(0);
        test_timeout(40);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
